pattern_count_engine: RTL and testbench

//  Memory-mastering accelerator for the pattern-count task. On start it reads a PAT_W-bit pattern
//  and an N_BYTES string from data memory, then computes three match counts. It writes the counts

---
 rtl/pattern_count_pkg.sv | 35 +++
 rtl/byte_window_matcher.sv | 52 +++++
 rtl/pattern_count_engine.sv | 204 ++++++++++++++++++++
 tb/tb_pattern_count_engine.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_count_pkg.sv
// Shared types and helpers for the pattern-count engine.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package pattern_count_pkg;

    typedef enum logic [3:0] {
        PCE_IDLE,
        PCE_RD_PAT,
        PCE_RD_MASK,
        PCE_RD_DATA,
        PCE_DRAIN,
        PCE_WR_CTB,
        PCE_WR_CTO,
        PCE_WR_CTS,
        PCE_DONE
    } pce_state_e;

    // Word offsets of the three results from the result base address.
    localparam int CTB_OFS = 0;
    localparam int CTO_OFS = 1;
    localparam int CTS_OFS = 2;

    // Counter width able to hold every window of the full bitstream.
    function automatic int pce_cnt_w(input int n_bytes, input int data_w);
        return $clog2(n_bytes * data_w + 1);
    endfunction

    // Clamp a count to the largest value a data_w-bit memory word can hold.
    function automatic int unsigned sat_to_data(input int unsigned cnt, input int unsigned data_w);
        int unsigned lim;
        lim = (data_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << data_w) - 32'd1);
        return (cnt > lim) ? lim : cnt;
    endfunction

endpackage

// File: rtl/byte_window_matcher.sv
// Counts masked pattern matches inside one byte and across the previous-byte boundary.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
module byte_window_matcher #(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 5,
    parameter int TAIL_W = (PAT_W > 1) ? PAT_W - 1 : 1,
    parameter int BW     = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] byte_i,
    input  logic [TAIL_W-1:0] tail_i,
    input  logic [PAT_W-1:0]  pat_i,
    input  logic [PAT_W-1:0]  mask_i,
    output logic [BW-1:0]     in_cnt_o,
    output logic              any_o,
    output logic [BW-1:0]     str_cnt_o
);

    // Previous byte's last bits sit above the current byte, so stream order is MSB first.
    localparam int CW = (PAT_W > 1) ? DATA_W + PAT_W - 1 : DATA_W;

    logic [CW-1:0]    cat;
    logic [PAT_W-1:0] win;

    if (PAT_W > 1) begin : g_cat
        assign cat = {tail_i, byte_i};
    end else begin : g_nocat
        assign cat = byte_i;
    end

    // Low windows lie wholly inside the byte; the top PAT_W-1 windows reach into the tail.
    always_comb begin
        in_cnt_o  = '0;
        str_cnt_o = '0;
        win       = '0;
        for (int k = 0; k <= DATA_W - PAT_W; k++) begin
            win = PAT_W'(cat >> k);
            if (((win ^ pat_i) & mask_i) == '0) begin
                in_cnt_o = in_cnt_o + BW'(1);
            end
        end
        for (int k = DATA_W - PAT_W + 1; k < DATA_W; k++) begin
            win = PAT_W'(cat >> k);
            if (((win ^ pat_i) & mask_i) == '0) begin
                str_cnt_o = str_cnt_o + BW'(1);
            end
        end
    end

    assign any_o = (in_cnt_o != '0);

endmodule

// File: rtl/pattern_count_engine.sv
// Reads a pattern and a string from memory, counts in-byte/byte-hit/stream matches, writes them back.
// Latency: done rises N_BYTES+6 cycles after start is sampled (N_BYTES+7 with PCE_MASK_EN defined).
// Backpressure: none; memory answers every read one cycle later and accepts every write.
module pattern_count_engine
    import pattern_count_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PAT_W     = 5,
    parameter int N_BYTES   = 32,
    parameter int ADDR_W    = 8,
    parameter int DATA_BASE = 0,
    parameter int PAT_ADDR  = 32,
    parameter int RES_ADDR  = 33,
    parameter int MASK_ADDR = 36,
    parameter int CNT_W     = pce_cnt_w(N_BYTES, DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [CNT_W-1:0]  ctb,
    output logic [CNT_W-1:0]  cto,
    output logic [CNT_W-1:0]  cts
);

    localparam int IDX_W  = $clog2(N_BYTES + 1);
    localparam int TAIL_W = (PAT_W > 1) ? PAT_W - 1 : 1;
    localparam int BW     = $clog2(DATA_W + 1);

    pce_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [TAIL_W-1:0] tail_q, tail_d;
    logic              have_tail_q, have_tail_d;
    logic [CNT_W-1:0]  ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d;
    logic [PAT_W-1:0]  mask_eff;
    logic              byte_vld;
    logic [BW-1:0]     in_cnt, str_cnt;
    logic              any_match;

`ifdef PCE_MASK_EN
    logic [PAT_W-1:0]  mask_q, mask_d;
    assign mask_eff = mask_q;
`else
    assign mask_eff = '1;
`endif

    byte_window_matcher #(
        .DATA_W (DATA_W),
        .PAT_W  (PAT_W),
        .TAIL_W (TAIL_W),
        .BW     (BW)
    ) u_matcher (
        .byte_i    (mem_rdata),
        .tail_i    (tail_q),
        .pat_i     (pat_q),
        .mask_i    (mask_eff),
        .in_cnt_o  (in_cnt),
        .any_o     (any_match),
        .str_cnt_o (str_cnt)
    );

    // State and datapath registers; reset abandons any run in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= PCE_IDLE;
            idx_q       <= '0;
            pat_q       <= '0;
            tail_q      <= '0;
            have_tail_q <= 1'b0;
            ctb_q       <= '0;
            cto_q       <= '0;
            cts_q       <= '0;
`ifdef PCE_MASK_EN
            mask_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pat_q       <= pat_d;
            tail_q      <= tail_d;
            have_tail_q <= have_tail_d;
            ctb_q       <= ctb_d;
            cto_q       <= cto_d;
            cts_q       <= cts_d;
`ifdef PCE_MASK_EN
            mask_q      <= mask_d;
`endif
        end
    end

    // Sequencing and count accumulation; read data always belongs to last cycle's address.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pat_d       = pat_q;
        tail_d      = tail_q;
        have_tail_d = have_tail_q;
        ctb_d       = ctb_q;
        cto_d       = cto_q;
        cts_d       = cts_q;
        byte_vld    = 1'b0;
`ifdef PCE_MASK_EN
        mask_d      = mask_q;
`endif
        case (state_q)
            PCE_IDLE, PCE_DONE: begin
                if (start) begin
                    state_d     = PCE_RD_PAT;
                    idx_d       = '0;
                    tail_d      = '0;
                    have_tail_d = 1'b0;
                    ctb_d       = '0;
                    cto_d       = '0;
                    cts_d       = '0;
                end
            end
            PCE_RD_PAT: begin
`ifdef PCE_MASK_EN
                state_d = PCE_RD_MASK;
`else
                state_d = PCE_RD_DATA;
`endif
            end
            PCE_RD_MASK: begin
                // Pattern word arrives while the mask address is out.
                pat_d   = mem_rdata[PAT_W-1:0];
                state_d = PCE_RD_DATA;
            end
            PCE_RD_DATA: begin
                // First data cycle receives the last setup word; later cycles receive byte idx-1.
                if (idx_q == '0) begin
`ifdef PCE_MASK_EN
                    mask_d = mem_rdata[PAT_W-1:0];
`else
                    pat_d  = mem_rdata[PAT_W-1:0];
`endif
                end else begin
                    byte_vld = 1'b1;
                end
                if (idx_q == IDX_W'(N_BYTES - 1)) begin
                    state_d = PCE_DRAIN;
                end
                idx_d = idx_q + IDX_W'(1);
            end
            PCE_DRAIN: begin
                byte_vld = 1'b1;
                state_d  = PCE_WR_CTB;
            end
            PCE_WR_CTB: state_d = PCE_WR_CTO;
            PCE_WR_CTO: state_d = PCE_WR_CTS;
            PCE_WR_CTS: state_d = PCE_DONE;
            default:    state_d = PCE_IDLE;
        endcase

        if (byte_vld) begin
            ctb_d       = ctb_q + CNT_W'(in_cnt);
            cto_d       = cto_q + CNT_W'(any_match);
            cts_d       = cts_q + CNT_W'(in_cnt) + (have_tail_q ? CNT_W'(str_cnt) : '0);
            tail_d      = mem_rdata[TAIL_W-1:0];
            have_tail_d = 1'b1;
        end
    end

    // Memory port decode; address parks at zero outside read and write states.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            PCE_RD_PAT:  mem_addr = ADDR_W'(PAT_ADDR);
            PCE_RD_MASK: mem_addr = ADDR_W'(MASK_ADDR);
            PCE_RD_DATA: mem_addr = ADDR_W'(DATA_BASE) + ADDR_W'(idx_q);
            PCE_WR_CTB: begin
                mem_we    = 1'b1;
                mem_addr  = ADDR_W'(RES_ADDR + CTB_OFS);
                mem_wdata = DATA_W'(sat_to_data(32'(ctb_q), DATA_W));
            end
            PCE_WR_CTO: begin
                mem_we    = 1'b1;
                mem_addr  = ADDR_W'(RES_ADDR + CTO_OFS);
                mem_wdata = DATA_W'(sat_to_data(32'(cto_q), DATA_W));
            end
            PCE_WR_CTS: begin
                mem_we    = 1'b1;
                mem_addr  = ADDR_W'(RES_ADDR + CTS_OFS);
                mem_wdata = DATA_W'(sat_to_data(32'(cts_q), DATA_W));
            end
            default: ;
        endcase
    end

    assign done = (state_q == PCE_DONE);
    assign busy = (state_q != PCE_IDLE) && (state_q != PCE_DONE);
    assign ctb  = ctb_q;
    assign cto  = cto_q;
    assign cts  = cts_q;

endmodule

// File: tb/tb_pattern_count_engine.sv
// Bench for pattern_count_engine: table vectors, reset-abort sequence and random runs vs a bitstream model.
// Latency: checks done arrives N_BYTES+6 cycles after start (N_BYTES+7 with PCE_MASK_EN).
// Backpressure: memory model answers every read one cycle after the address.
`timescale 1ns/1ps
module tb_pattern_count_engine;

    localparam int DATA_W    = 8;
    localparam int PAT_W     = 5;
    localparam int N_BYTES   = 32;
    localparam int ADDR_W    = 8;
    localparam int DATA_BASE = 0;
    localparam int PAT_ADDR  = 32;
    localparam int RES_ADDR  = 33;
    localparam int MASK_ADDR = 36;
    localparam int CNT_W     = $clog2(N_BYTES * DATA_W + 1);
`ifdef PCE_MASK_EN
    localparam int LAT = N_BYTES + 7;
`else
    localparam int LAT = N_BYTES + 6;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              done, busy, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] mem_wdata;
    logic [CNT_W-1:0]  ctb, cto, cts;

    // Read image is written only by the stimulus; writes land in a separate array.
    logic [7:0] img  [0:255];
    logic [7:0] wmem [0:255];
    int         we_total = 0;
    logic       mask_touched = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] fill;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [4:0] pat;
        int         ctb;
        int         cto;
        int         cts;
    } vec_t;
    vec_t vecs[4];

    pattern_count_engine dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .ctb       (ctb),
        .cto       (cto),
        .cts       (cts)
    );

    always #5 clk = ~clk;

    // Synchronous memory: one-cycle read latency, write log, access monitor.
    always @(posedge clk) begin
        mem_rdata <= img[mem_addr];
        if (mem_we) begin
            wmem[mem_addr] <= mem_wdata;
            we_total       <= we_total + 1;
        end
        if (mem_addr == 8'(MASK_ADDR)) mask_touched <= 1'b1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int stream_bit(input int j);
        logic [7:0] b;
        b = img[DATA_BASE + j / DATA_W];
        return int'(b[DATA_W - 1 - (j % DATA_W)]);
    endfunction

    // Slide a window over the whole bitstream, byte 0 / MSB first.
    task automatic model(input logic [4:0] pat, input logic [4:0] msk,
                         output int e_ctb, output int e_cto, output int e_cts);
        bit hit [N_BYTES];
        e_ctb = 0;
        e_cto = 0;
        e_cts = 0;
        for (int i = 0; i < N_BYTES; i++) hit[i] = 1'b0;
        for (int p = 0; p <= N_BYTES * DATA_W - PAT_W; p++) begin
            int w;
            w = 0;
            for (int j = 0; j < PAT_W; j++) w = w * 2 + stream_bit(p + j);
            if (((w ^ int'(pat)) & int'(msk)) == 0) begin
                e_cts++;
                if (p / DATA_W == (p + PAT_W - 1) / DATA_W) begin
                    e_ctb++;
                    hit[p / DATA_W] = 1'b1;
                end
            end
        end
        for (int i = 0; i < N_BYTES; i++) if (hit[i]) e_cto++;
    endtask

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic load(input logic [7:0] fill, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [4:0] pat);
        for (int i = 0; i < N_BYTES; i++) img[DATA_BASE + i] = fill;
        img[DATA_BASE]     = b0;
        img[DATA_BASE + 1] = b1;
        // Upper bits are junk the engine must ignore.
        img[PAT_ADDR] = {3'b101, pat};
    endtask

    task automatic do_run(input string tag, input int e_ctb, input int e_cto, input int e_cts);
        int cyc;
        int we0;
        bit was_done;
        we0      = we_total;
        was_done = done;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        if (was_done) check({tag, " done drops after start"}, int'(done), 0);
        check({tag, " busy after start"}, int'(busy), 1);
        while (!done && cyc < LAT + 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, LAT);
        check({tag, " ctb"}, int'(ctb), e_ctb);
        check({tag, " cto"}, int'(cto), e_cto);
        check({tag, " cts"}, int'(cts), e_cts);
        check({tag, " mem ctb"}, int'(wmem[RES_ADDR]), sat8(e_ctb));
        check({tag, " mem cto"}, int'(wmem[RES_ADDR + 1]), sat8(e_cto));
        check({tag, " mem cts"}, int'(wmem[RES_ADDR + 2]), sat8(e_cts));
        check({tag, " write count"}, we_total - we0, 3);
        @(posedge clk);
        #1;
        check({tag, " done held"}, int'(done), 1);
        check({tag, " cts held"}, int'(cts), e_cts);
        check({tag, " addr parked"}, int'(mem_addr), 0);
    endtask

    initial begin
        int e_ctb, e_cto, e_cts;
        logic [4:0] pat, msk;
        logic [7:0] bias;

        vecs[0] = '{8'h55, 8'h55, 8'h55, 5'b10101,  64, 32, 126};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 5'b00000, 128, 32, 252};
        vecs[2] = '{8'h00, 8'hF8, 8'h00, 5'b11111,   1,  1,   1};
        vecs[3] = '{8'h00, 8'h03, 8'hE0, 5'b11111,   0,  0,   1};

        for (int i = 0; i < 256; i++) begin
            img[i] = 8'h00;
        end
        img[MASK_ADDR] = 8'hFF;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset done", int'(done), 0);
        check("reset busy", int'(busy), 0);
        check("reset we", int'(mem_we), 0);
        check("reset addr", int'(mem_addr), 0);
        check("reset ctb", int'(ctb), 0);
        check("reset cto", int'(cto), 0);
        check("reset cts", int'(cts), 0);
        @(negedge clk);
        reset = 1'b1;

        // Table vectors.
        for (int v = 0; v < 4; v++) begin
            load(vecs[v].fill, vecs[v].b0, vecs[v].b1, vecs[v].pat);
            do_run($sformatf("vec%0d", v), vecs[v].ctb, vecs[v].cto, vecs[v].cts);
        end

        // Reset in the middle of a run.
        load(8'h55, 8'h55, 8'h55, 5'b10101);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort busy before reset", int'(busy), 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort done", int'(done), 0);
        check("abort busy", int'(busy), 0);
        check("abort we", int'(mem_we), 0);
        check("abort addr", int'(mem_addr), 0);
        check("abort ctb", int'(ctb), 0);
        check("abort cto", int'(cto), 0);
        check("abort cts", int'(cts), 0);
        @(negedge clk);
        reset = 1'b1;
        do_run("after abort", 64, 32, 126);

`ifdef PCE_MASK_EN
        // All-don't-care mask: every window matches regardless of data.
        for (int i = 0; i < N_BYTES; i++) img[DATA_BASE + i] = 8'($urandom);
        img[PAT_ADDR]  = 8'($urandom);
        img[MASK_ADDR] = 8'hE0;
        do_run("mask zero", 128, 32, 252);
`endif

        // Random runs against the bitstream model.
        for (int r = 0; r < 6; r++) begin
            bias = (r % 2 == 0) ? 8'hFF : 8'h81;
            for (int i = 0; i < N_BYTES; i++) img[DATA_BASE + i] = 8'($urandom) & bias;
            pat = 5'($urandom_range(0, 31));
            img[PAT_ADDR] = {3'($urandom), pat};
`ifdef PCE_MASK_EN
            msk = 5'($urandom_range(0, 31));
            img[MASK_ADDR] = {3'($urandom), msk};
`else
            msk = 5'h1F;
`endif
            model(pat, msk, e_ctb, e_cto, e_cts);
            do_run($sformatf("rand%0d", r), e_ctb, e_cto, e_cts);
        end

`ifndef PCE_MASK_EN
        check("mask location untouched", int'(mask_touched), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
